multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: fetch/decode/execute/memory/writeback sequencing
// with memory-ready timeouts and sticky trap causes (illegal opcode, bus error).
module multicycle_control #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       imem_ready,
  input  logic [6:0] imem_opcode,
  input  logic       dmem_ready,
  input  logic       brTaken,
  output logic       imem_req,
  output logic       irWe,
  output logic       dmem_req,
  output logic       RAMwe,
  output logic       Regwe,
  output logic       pcWe,
  output logic [1:0] pcSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrc1,
  output logic       ALUSrc2,
  output logic [1:0] RegWriteSrc,
  output logic       illegal,
  output logic       busErr
);

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_OPIMM  = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_OP     = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [9:0] cnt_q, cnt_d;
  logic       ill_q, ill_d;
  logic       berr_q, berr_d;
  // Holds fetch off until the first clock edge after reset release.
  logic       run_q;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  // Returns {ALUOp, ALUSrc1, ALUSrc2} for the latched opcode.
  function automatic logic [4:0] alu_ctrl(input logic [6:0] op);
    logic [1:0] aop;
    logic [1:0] src1;
    logic       src2;
    case (op)
      OP_OPIMM, OP_OP: aop = 2'b00;
      OP_BRANCH:       aop = 2'b01;
      default:         aop = 2'b10;
    endcase
    case (op)
      OP_AUIPC: src1 = 2'b10;
      OP_LUI:   src1 = 2'b01;
      default:  src1 = 2'b00;
    endcase
    src2 = (op == OP_OP) || (op == OP_BRANCH);
    alu_ctrl = {aop, src1, src2};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= 7'd0;
      cnt_q   <= 10'd0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    ill_d       = ill_q;
    berr_d      = berr_q;
    imem_req    = 1'b0;
    irWe        = 1'b0;
    dmem_req    = 1'b0;
    RAMwe       = 1'b0;
    Regwe       = 1'b0;
    pcWe        = 1'b0;
    pcSrc       = 2'b00;
    ALUOp       = 2'b00;
    ALUSrc1     = 2'b00;
    ALUSrc2     = 1'b0;
    RegWriteSrc = 2'b00;

    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            irWe    = 1'b1;
            op_d    = imem_opcode;
            state_d = S_DECODE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_TRAP;
            berr_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      S_DECODE: begin
        if (is_legal(op_q)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          ill_d   = 1'b1;
        end
      end
      S_EXEC: begin
        {ALUOp, ALUSrc1, ALUSrc2} = alu_ctrl(op_q);
        case (op_q)
          OP_LOAD, OP_STORE: begin
            state_d = S_MEM;
            cnt_d   = 10'd0;
          end
          OP_BRANCH: begin
            pcWe    = 1'b1;
            pcSrc   = brTaken ? 2'b01 : 2'b00;
            state_d = S_FETCH;
            cnt_d   = 10'd0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        {ALUOp, ALUSrc1, ALUSrc2} = alu_ctrl(op_q);
        dmem_req = 1'b1;
        RAMwe    = (op_q == OP_STORE);
        if (dmem_ready) begin
          if (op_q == OP_STORE) begin
            pcWe    = 1'b1;
            state_d = S_FETCH;
            cnt_d   = 10'd0;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TRAP;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_WB: begin
        Regwe = 1'b1;
        pcWe  = 1'b1;
        if (op_q == OP_LOAD) begin
          RegWriteSrc = 2'b00;
        end else if ((op_q == OP_JAL) || (op_q == OP_JALR)) begin
          RegWriteSrc = 2'b10;
        end else begin
          RegWriteSrc = 2'b01;
        end
        pcSrc   = ((op_q == OP_JAL) || (op_q == OP_JALR)) ? 2'b10 : 2'b00;
        state_d = S_FETCH;
        cnt_d   = 10'd0;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  assign illegal = ill_q;
  assign busErr  = berr_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control vectors are
// queued with their stimulus, then replayed and compared against the DUT.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_ready = 1'b0;
  logic [6:0] imem_opcode = 7'd0;
  logic       dmem_ready = 1'b0;
  logic       brTaken = 1'b0;
  logic       imem_req, irWe, dmem_req, RAMwe, Regwe, pcWe, ALUSrc2, illegal, busErr;
  logic [1:0] pcSrc, ALUOp, ALUSrc1, RegWriteSrc;

  int total = 0;
  int bad = 0;

  logic [9:0]  stim_q[$];
  logic [16:0] exp_q[$];
  logic [16:0] outv;

  multicycle_control #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .imem_opcode(imem_opcode),
    .dmem_ready(dmem_ready), .brTaken(brTaken), .imem_req(imem_req), .irWe(irWe),
    .dmem_req(dmem_req), .RAMwe(RAMwe), .Regwe(Regwe), .pcWe(pcWe), .pcSrc(pcSrc),
    .ALUOp(ALUOp), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .RegWriteSrc(RegWriteSrc),
    .illegal(illegal), .busErr(busErr)
  );

  always #5 clk = ~clk;

  assign outv = {imem_req, irWe, dmem_req, RAMwe, Regwe, pcWe, pcSrc, ALUOp,
                 ALUSrc1, ALUSrc2, RegWriteSrc, illegal, busErr};

  function automatic logic [16:0] ev(input logic imr, irw, dr, rw, rgw, pcw,
                                     input logic [1:0] pcs, aop, s1, input logic s2,
                                     input logic [1:0] rws, input logic ill, be);
    return {imr, irw, dr, rw, rgw, pcw, pcs, aop, s1, s2, rws, ill, be};
  endfunction

  task automatic push(input logic [9:0] s, input logic [16:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Expected trace of one retired instruction: fw fetch stalls, dw memory stalls.
  task automatic push_instr(input logic [6:0] op, input logic br, input int fw, input int dw);
    logic [1:0] aop, s1, rws, pcs;
    logic       s2, st;
    for (int i = 0; i < fw; i++) push({3'b000, op}, ev(1,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0));
    push({3'b100, op}, ev(1,1,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0));
    push({3'b000, op}, 17'd0);
    aop = (op == 7'd19 || op == 7'd51) ? 2'b00 : (op == 7'd99) ? 2'b01 : 2'b10;
    s1  = (op == 7'd23) ? 2'b10 : (op == 7'd55) ? 2'b01 : 2'b00;
    s2  = (op == 7'd51 || op == 7'd99);
    st  = (op == 7'd35);
    if (op == 7'd99) begin
      push({2'b00, br, op}, ev(0,0,0,0,0,1, br ? 2'b01 : 2'b00, aop, s1, s2, 2'd0, 0, 0));
      return;
    end
    push({3'b000, op}, ev(0,0,0,0,0,0,2'd0,aop,s1,s2,2'd0,0,0));
    if (op == 7'd3 || op == 7'd35) begin
      for (int i = 0; i < dw; i++) push({3'b000, op}, ev(0,0,1,st,0,0,2'd0,aop,s1,s2,2'd0,0,0));
      push({3'b010, op}, ev(0,0,1,st,0,st,2'd0,aop,s1,s2,2'd0,0,0));
      if (st) return;
    end
    rws = (op == 7'd3) ? 2'b00 : (op == 7'd103 || op == 7'd111) ? 2'b10 : 2'b01;
    pcs = (op == 7'd103 || op == 7'd111) ? 2'b10 : 2'b00;
    push({3'b000, op}, ev(0,0,0,0,1,1,pcs,2'd0,2'd0,0,rws,0,0));
  endtask

  task automatic drive(input logic [9:0] s);
    {imem_ready, dmem_ready, brTaken, imem_opcode} = s;
  endtask

  // Leaves the bench at posedge+1 of the first active FETCH cycle.
  task automatic do_reset();
    drive(10'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive({3'b100, 7'd51});
    rst_n = 1'b0;
    #3;
    total++;
    if (outv !== 17'd0) begin bad++; $display("FAIL reset_hold got=%h want=%h", outv, 17'd0); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_release_req got=%b want=0", imem_req); end
    drive(10'd0);
    @(posedge clk);
    #1;
    total++;
    if (outv !== ev(1,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0)) begin
      bad++; $display("FAIL reset_first_fetch got=%h want=%h", outv, ev(1,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0));
    end
  endtask

  task automatic test_alu();
    logic [9:0] s; logic [16:0] e;
    push_instr(7'd51, 0, 0, 0);
    push_instr(7'd19, 0, 2, 0);
    push_instr(7'd55, 0, 0, 0);
    push_instr(7'd23, 0, 1, 0);
    push_instr(7'd111, 0, 0, 0);
    push_instr(7'd103, 0, 0, 0);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk); e = exp_q.pop_front(); total++;
      if (outv !== e) begin bad++; $display("FAIL alu op=%0d got=%h want=%h", s[6:0], outv, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem();
    logic [9:0] s; logic [16:0] e;
    push_instr(7'd3, 0, 0, 2);
    push_instr(7'd35, 0, 0, 0);
    push_instr(7'd35, 0, 1, 1);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk); e = exp_q.pop_front(); total++;
      if (outv !== e) begin bad++; $display("FAIL mem op=%0d got=%h want=%h", s[6:0], outv, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [9:0] s; logic [16:0] e;
    push_instr(7'd99, 1, 0, 0);
    push_instr(7'd99, 0, 0, 0);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk); e = exp_q.pop_front(); total++;
      if (outv !== e) begin bad++; $display("FAIL branch br=%b got=%h want=%h", s[7], outv, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] s; logic [16:0] e;
    logic [6:0] ops[6] = '{7'd51, 7'd3, 7'd99, 7'd35, 7'd111, 7'd23};
    for (int i = 0; i < 6; i++) push_instr(ops[i], 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk); e = exp_q.pop_front(); total++;
      if (outv !== e) begin bad++; $display("FAIL b2b op=%0d got=%h want=%h", s[6:0], outv, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [9:0] s; logic [16:0] e;
    push({3'b100, 7'd0}, ev(1,1,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0));
    push({3'b000, 7'd0}, 17'd0);
    for (int i = 0; i < 20; i++) push({3'b111, 7'd51}, ev(0,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,1,0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk); e = exp_q.pop_front(); total++;
      if (outv !== e) begin bad++; $display("FAIL illegal got=%h want=%h", outv, e); end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (outv !== 17'd0) begin bad++; $display("FAIL illegal_clear got=%h want=%h", outv, 17'd0); end
    do_reset();
    total++;
    if (outv !== ev(1,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0)) begin
      bad++; $display("FAIL illegal_refetch got=%h want=%h", outv, ev(1,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0));
    end
  endtask

  task automatic test_timeout();
    logic [9:0] s; logic [16:0] e;
    for (int i = 0; i < 4; i++) push({3'b000, 7'd51}, ev(1,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0));
    for (int i = 0; i < 3; i++) push({3'b110, 7'd51}, ev(0,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,1));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk); e = exp_q.pop_front(); total++;
      if (outv !== e) begin bad++; $display("FAIL fetch_timeout got=%h want=%h", outv, e); end
      @(posedge clk); #1;
    end
    do_reset();
    push_instr(7'd51, 0, 3, 0);
    push({3'b100, 7'd3}, ev(1,1,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0));
    push({3'b000, 7'd3}, 17'd0);
    push({3'b000, 7'd3}, ev(0,0,0,0,0,0,2'd0,2'b10,2'd0,0,2'd0,0,0));
    for (int i = 0; i < 4; i++) push({3'b000, 7'd3}, ev(0,0,1,0,0,0,2'd0,2'b10,2'd0,0,2'd0,0,0));
    for (int i = 0; i < 2; i++) push({3'b110, 7'd3}, ev(0,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,1));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk); e = exp_q.pop_front(); total++;
      if (outv !== e) begin bad++; $display("FAIL timeout_edge op=%0d got=%h want=%h", s[6:0], outv, e); end
      @(posedge clk); #1;
    end
    do_reset();
    push_instr(7'd3, 0, 0, 3);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk); e = exp_q.pop_front(); total++;
      if (outv !== e) begin bad++; $display("FAIL mem_ready_at_limit got=%h want=%h", outv, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [9:0] s; logic [16:0] e;
    push({3'b100, 7'd35}, ev(1,1,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0));
    push({3'b000, 7'd35}, 17'd0);
    push({3'b000, 7'd35}, ev(0,0,0,0,0,0,2'd0,2'b10,2'd0,0,2'd0,0,0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk); e = exp_q.pop_front(); total++;
      if (outv !== e) begin bad++; $display("FAIL sw_abort_lead got=%h want=%h", outv, e); end
      @(posedge clk); #1;
    end
    drive({3'b000, 7'd35});
    #2;
    total++;
    if ({dmem_req, RAMwe} !== 2'b11) begin bad++; $display("FAIL sw_in_mem got=%b want=11", {dmem_req, RAMwe}); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({dmem_req, RAMwe, Regwe, pcWe} !== 4'b0000) begin
      bad++; $display("FAIL sw_abort_drop got=%b want=0000", {dmem_req, RAMwe, Regwe, pcWe});
    end
    drive({3'b010, 7'd35});
    @(posedge clk); #1;
    total++;
    if (outv !== 17'd0) begin bad++; $display("FAIL sw_abort_held got=%h want=%h", outv, 17'd0); end
    drive(10'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (outv !== ev(1,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0)) begin
      bad++; $display("FAIL sw_abort_fetch got=%h want=%h", outv, ev(1,0,0,0,0,0,2'd0,2'd0,2'd0,0,2'd0,0,0));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_timeout();
    do_reset();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
